// File: rtl/axi4_pkg.sv
// Shared AXI4 constants, FSM state types and response-priority helper.
// Combinational only; no latency, no backpressure.
package axi4_pkg;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_EXOKAY = 2'd1;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   typedef enum logic       {R_IDLE, R_DATA}          r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_t;

   // Encodings are ordered by severity, so the worse response is the larger one.
   function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/axi4_s_mem_array.sv
// MEM_DEPTH x DATA_SIZE storage: byte-enabled write port, synchronous read port.
// Read data appears one cycle after rd_en_i and holds while rd_en_i is low; same-edge write returns old data.
module axi4_s_mem_array #(
   parameter int DATA_SIZE = 32,
   parameter int MEM_DEPTH = 1024,
   parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
   input  logic                   clk_i,
   input  logic                   wr_en_i,
   input  logic [IDX_W-1:0]       wr_idx_i,
   input  logic [DATA_SIZE/8-1:0] wr_be_i,
   input  logic [DATA_SIZE-1:0]   wr_dat_i,
   input  logic                   rd_en_i,
   input  logic [IDX_W-1:0]       rd_idx_i,
   output logic [DATA_SIZE-1:0]   rd_dat_o
);

   localparam int NB = DATA_SIZE / 8;

   logic [DATA_SIZE-1:0] mem_q [MEM_DEPTH];
   logic [DATA_SIZE-1:0] rd_dat_q;

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NB; b++) begin
         if (wr_en_i && wr_be_i[b]) begin
            mem_q[wr_idx_i][b*8 +: 8] <= wr_dat_i[b*8 +: 8];
         end
      end
      if (rd_en_i) begin
         rd_dat_q <= mem_q[rd_idx_i];
      end
   end

   assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/axi4_s_mem.sv
// AXI4 slave memory, independent read/write paths with one outstanding burst each; first R beat 1 cycle after AR.
// R beats advance only on rready, W on wvalid, B held until bready; AXI4_S_MEM_WSTRB_EN enables byte-lane writes.
module axi4_s_mem
   import axi4_pkg::*;
#(
   parameter int ADDRESS_SIZE = 32,
   parameter int DATA_SIZE    = 32,
   parameter int MEM_DEPTH    = 1024
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [ADDRESS_SIZE-1:0] s_axi_araddr,
   input  logic [7:0]              s_axi_arlen,
   input  logic [2:0]              s_axi_arsize,
   input  logic [1:0]              s_axi_arburst,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_SIZE-1:0]    s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rlast,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   input  logic [ADDRESS_SIZE-1:0] s_axi_awaddr,
   input  logic [7:0]              s_axi_awlen,
   input  logic [2:0]              s_axi_awsize,
   input  logic [1:0]              s_axi_awburst,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_SIZE-1:0]    s_axi_wdata,
   input  logic [DATA_SIZE/8-1:0]  s_axi_wstrb,
   input  logic                    s_axi_wlast,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready
);

   localparam int NB    = DATA_SIZE / 8;
   localparam int BSH   = $clog2(NB);
   localparam int IDX_W = $clog2(MEM_DEPTH);

   function automatic logic [1:0] beat_resp(input logic [ADDRESS_SIZE-1:0] addr,
                                            input logic [2:0] size, input logic [1:0] burst);
      logic [ADDRESS_SIZE-1:0] widx;
      widx = addr >> BSH;
      if ((widx >> IDX_W) != '0) return RESP_DECERR;
      if (burst != BURST_INCR || size > 3'(BSH)) return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

   r_state_t                r_state_q, r_state_d;
   w_state_t                w_state_q, w_state_d;
   logic                    rdy_q;
   logic [ADDRESS_SIZE-1:0] raddr_q, rd_addr, waddr_q;
   logic [7:0]              rlen_q, rcnt_q, wlen_q, wcnt_q;
   logic [2:0]              rsize_q, wsize_q;
   logic [1:0]              rburst_q, wburst_q, rresp_q, bresp_q, rd_resp, wr_resp;
   logic                    ar_hs, r_hs, r_last, r_fetch;
   logic                    aw_hs, w_hs, b_hs, w_last_beat, wlast_err, wr_en;
   logic [NB-1:0]           wr_be;
   logic [DATA_SIZE-1:0]    arr_rd_dat;

   assign ar_hs   = s_axi_arvalid && s_axi_arready;
   assign r_hs    = s_axi_rvalid && s_axi_rready;
   assign r_last  = (rcnt_q == rlen_q);
   assign r_fetch = ar_hs || (r_hs && !r_last);
   assign rd_addr = ar_hs ? s_axi_araddr : raddr_q + (ADDRESS_SIZE'(1) << rsize_q);
   assign rd_resp = ar_hs ? beat_resp(s_axi_araddr, s_axi_arsize, s_axi_arburst)
                          : beat_resp(rd_addr, rsize_q, rburst_q);

   assign aw_hs       = s_axi_awvalid && s_axi_awready;
   assign w_hs        = s_axi_wvalid && s_axi_wready;
   assign b_hs        = s_axi_bvalid && s_axi_bready;
   assign w_last_beat = (wcnt_q == wlen_q);
   assign wlast_err   = (s_axi_wlast != w_last_beat);
   assign wr_resp     = beat_resp(waddr_q, wsize_q, wburst_q);
   assign wr_en       = w_hs && (wr_resp == RESP_OKAY);

`ifdef AXI4_S_MEM_WSTRB_EN
   assign wr_be = s_axi_wstrb;
`else
   logic wstrb_unused;
   assign wstrb_unused = ^s_axi_wstrb;
   assign wr_be        = '1;
`endif

   // rdy_q keeps both address channels closed until the first edge out of reset.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state_q <= R_IDLE;
         w_state_q <= W_IDLE;
         rdy_q     <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         w_state_q <= w_state_d;
         rdy_q     <= 1'b1;
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (ar_hs) r_state_d = R_DATA;
         R_DATA:  if (r_hs && r_last) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE:  if (aw_hs) w_state_d = W_DATA;
         W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
         W_RESP:  if (b_hs) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      s_axi_arready = rdy_q && (r_state_q == R_IDLE);
      s_axi_rvalid  = (r_state_q == R_DATA);
      s_axi_rlast   = s_axi_rvalid && r_last;
      s_axi_rresp   = s_axi_rvalid ? rresp_q : RESP_OKAY;
      s_axi_rdata   = (s_axi_rvalid && rresp_q == RESP_OKAY) ? arr_rd_dat : '0;
      s_axi_awready = rdy_q && (w_state_q == W_IDLE);
      s_axi_wready  = (w_state_q == W_DATA);
      s_axi_bvalid  = (w_state_q == W_RESP);
      s_axi_bresp   = bresp_q;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         raddr_q  <= '0;
         rlen_q   <= '0;
         rcnt_q   <= '0;
         rsize_q  <= '0;
         rburst_q <= BURST_FIXED;
         rresp_q  <= RESP_OKAY;
         waddr_q  <= '0;
         wlen_q   <= '0;
         wcnt_q   <= '0;
         wsize_q  <= '0;
         wburst_q <= BURST_FIXED;
         bresp_q  <= RESP_OKAY;
      end else begin
         if (ar_hs) begin
            rlen_q   <= s_axi_arlen;
            rsize_q  <= s_axi_arsize;
            rburst_q <= s_axi_arburst;
            rcnt_q   <= '0;
         end else if (r_hs && !r_last) begin
            rcnt_q <= rcnt_q + 8'd1;
         end
         if (r_fetch) begin
            raddr_q <= rd_addr;
            rresp_q <= rd_resp;
         end
         if (aw_hs) begin
            waddr_q  <= s_axi_awaddr;
            wlen_q   <= s_axi_awlen;
            wsize_q  <= s_axi_awsize;
            wburst_q <= s_axi_awburst;
            wcnt_q   <= '0;
            bresp_q  <= RESP_OKAY;
         end else if (w_hs) begin
            waddr_q <= waddr_q + (ADDRESS_SIZE'(1) << wsize_q);
            wcnt_q  <= wcnt_q + 8'd1;
            bresp_q <= resp_max(resp_max(bresp_q, wr_resp), wlast_err ? RESP_SLVERR : RESP_OKAY);
         end
      end
   end

   axi4_s_mem_array #(
      .DATA_SIZE (DATA_SIZE),
      .MEM_DEPTH (MEM_DEPTH),
      .IDX_W     (IDX_W)
   ) u_array (
      .clk_i    (aclk),
      .wr_en_i  (wr_en),
      .wr_idx_i (waddr_q[BSH +: IDX_W]),
      .wr_be_i  (wr_be),
      .wr_dat_i (s_axi_wdata),
      .rd_en_i  (r_fetch),
      .rd_idx_i (rd_addr[BSH +: IDX_W]),
      .rd_dat_o (arr_rd_dat)
   );

endmodule

// File: tb/tb_axi4_s_mem.sv
// Directed bench for axi4_s_mem: bursts, stalls, error responses, strobes and mid-burst reset.
module tb_axi4_s_mem;

   logic        aclk = 1'b0;
   logic        areset;
   logic [31:0] s_axi_araddr;
   logic [7:0]  s_axi_arlen;
   logic [2:0]  s_axi_arsize;
   logic [1:0]  s_axi_arburst;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rlast;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic [31:0] s_axi_awaddr;
   logic [7:0]  s_axi_awlen;
   logic [2:0]  s_axi_awsize;
   logic [1:0]  s_axi_awburst;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wlast;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;

   int checks   = 0;
   int failures = 0;

   logic [31:0] rb_dat  [16];
   logic [1:0]  rb_resp [16];
   logic        rb_last [16];
   logic        rb_first;
   int          rb_cyc;

   always #5 aclk = ~aclk;

   axi4_s_mem dut (
      .aclk(aclk), .areset(areset),
      .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
      .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
      .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                              input logic [31:0] base, input logic [3:0] strb, input bit early,
                              output logic [1:0] resp);
      int n;
      s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = 3'd2; s_axi_awburst = burst;
      s_axi_awvalid = 1'b1;
      n = 0;
      while (!s_axi_awready && n < 50) begin @(posedge aclk); #1; n++; end
      chk("aw_ready", s_axi_awready, 1);
      @(posedge aclk); #1;
      s_axi_awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         s_axi_wdata  = base + i;
         s_axi_wstrb  = strb;
         s_axi_wlast  = early ? (i == 0) : (i == int'(len));
         s_axi_wvalid = 1'b1;
         n = 0;
         while (!s_axi_wready && n < 50) begin @(posedge aclk); #1; n++; end
         chk("w_ready", s_axi_wready, 1);
         @(posedge aclk); #1;
      end
      s_axi_wvalid = 1'b0;
      s_axi_wlast  = 1'b0;
      s_axi_bready = 1'b1;
      n = 0;
      while (!s_axi_bvalid && n < 50) begin @(posedge aclk); #1; n++; end
      chk("b_valid", s_axi_bvalid, 1);
      resp = s_axi_bresp;
      @(posedge aclk); #1;
      s_axi_bready = 1'b0;
      chk("b_single", s_axi_bvalid, 0);
   endtask

   task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input bit toggle);
      int n, beat, cyc;
      logic stall, sl;
      logic [31:0] sd;
      logic [1:0] sr;
      s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = 3'd2; s_axi_arburst = burst;
      s_axi_arvalid = 1'b1;
      n = 0;
      while (!s_axi_arready && n < 50) begin @(posedge aclk); #1; n++; end
      chk("ar_ready", s_axi_arready, 1);
      @(posedge aclk); #1;
      s_axi_arvalid = 1'b0;
      rb_first = s_axi_rvalid;
      beat = 0; cyc = 0; stall = 1'b0; sd = '0; sl = 1'b0; sr = '0;
      while (beat <= int'(len) && cyc < 200) begin
         s_axi_rready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (s_axi_rvalid) begin
            if (stall) begin
               chk("r_hold_dat", s_axi_rdata, sd);
               chk("r_hold_last", s_axi_rlast, sl);
               chk("r_hold_resp", s_axi_rresp, sr);
            end
            if (s_axi_rready) begin
               if (beat < 16) begin
                  rb_dat[beat] = s_axi_rdata; rb_resp[beat] = s_axi_rresp; rb_last[beat] = s_axi_rlast;
               end
               beat++;
               stall = 1'b0;
            end else begin
               sd = s_axi_rdata; sl = s_axi_rlast; sr = s_axi_rresp;
               stall = 1'b1;
            end
         end
         @(posedge aclk); #1;
         cyc++;
      end
      s_axi_rready = 1'b0;
      rb_cyc = cyc;
      chk("r_beats", beat, int'(len) + 1);
      chk("r_arready_back", s_axi_arready, 1);
      chk("r_rvalid_done", s_axi_rvalid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] br;
      logic [31:0] exp_strb;
      int n;
      areset = 1'b1;
      s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0; s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0;
      s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0; s_axi_awvalid = 1'b0;
      s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;

      // Reset state
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_arready", s_axi_arready, 0);
      chk("rst_awready", s_axi_awready, 0);
      chk("rst_rvalid", s_axi_rvalid, 0);
      chk("rst_rlast", s_axi_rlast, 0);
      chk("rst_wready", s_axi_wready, 0);
      chk("rst_bvalid", s_axi_bvalid, 0);
      chk("rst_rdata", s_axi_rdata, 0);
      chk("rst_rresp", s_axi_rresp, 0);
      chk("rst_bresp", s_axi_bresp, 0);
      @(negedge aclk);
      areset = 1'b0;
      #1;
      chk("rel_arready_pre", s_axi_arready, 0);
      @(posedge aclk); #1;
      chk("rel_arready", s_axi_arready, 1);
      chk("rel_awready", s_axi_awready, 1);

      // INCR write/read of four words
      write_burst(32'h100, 8'd3, 2'd1, 32'hA0, 4'hF, 1'b0, br);
      chk("incr_bresp", br, 0);
      read_burst(32'h100, 8'd3, 2'd1, 1'b0);
      chk("incr_first_rvalid", rb_first, 1);
      chk("incr_cycles", rb_cyc, 4);
      for (int i = 0; i < 4; i++) begin
         chk("incr_rdata", rb_dat[i], 32'hA0 + i);
         chk("incr_rresp", rb_resp[i], 0);
         chk("incr_rlast", rb_last[i], (i == 3));
      end

      // Eight-beat read with rready toggling
      write_burst(32'h200, 8'd7, 2'd1, 32'hB0, 4'hF, 1'b0, br);
      chk("len7_bresp", br, 0);
      read_burst(32'h200, 8'd7, 2'd1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         chk("len7_rdata", rb_dat[i], 32'hB0 + i);
         chk("len7_rlast", rb_last[i], (i == 7));
      end

      // Decode errors at the top of memory
      write_burst(32'h1000, 8'd0, 2'd1, 32'hDEAD0000, 4'hF, 1'b0, br);
      chk("decerr_bresp", br, 3);
      write_burst(32'hFFC, 8'd0, 2'd1, 32'hC0, 4'hF, 1'b0, br);
      chk("top_bresp", br, 0);
      read_burst(32'hFFC, 8'd1, 2'd1, 1'b0);
      chk("top_b0_resp", rb_resp[0], 0);
      chk("top_b0_data", rb_dat[0], 32'hC0);
      chk("top_b1_resp", rb_resp[1], 3);
      chk("top_b1_data", rb_dat[1], 0);
      chk("top_b1_last", rb_last[1], 1);

      // Byte strobes
      write_burst(32'h300, 8'd0, 2'd1, 32'h12345678, 4'hF, 1'b0, br);
      write_burst(32'h300, 8'd0, 2'd1, 32'hFFFFFFFF, 4'h3, 1'b0, br);
      chk("strb_bresp", br, 0);
`ifdef AXI4_S_MEM_WSTRB_EN
      exp_strb = 32'h1234FFFF;
`else
      exp_strb = 32'hFFFFFFFF;
`endif
      read_burst(32'h300, 8'd0, 2'd1, 1'b0);
      chk("strb_rdata", rb_dat[0], exp_strb);

      // Unsupported burst type and early wlast
      read_burst(32'h100, 8'd1, 2'd0, 1'b0);
      chk("fixed_b0_resp", rb_resp[0], 2);
      chk("fixed_b1_resp", rb_resp[1], 2);
      chk("fixed_b0_data", rb_dat[0], 0);
      chk("fixed_b1_last", rb_last[1], 1);
      write_burst(32'h400, 8'd2, 2'd1, 32'hD0, 4'hF, 1'b1, br);
      chk("early_wlast_bresp", br, 2);
      read_burst(32'h400, 8'd2, 2'd1, 1'b0);
      for (int i = 0; i < 3; i++) chk("early_wlast_data", rb_dat[i], 32'hD0 + i);

      // Reset during the second beat of a four-beat read
      s_axi_araddr = 32'h100; s_axi_arlen = 8'd3; s_axi_arsize = 3'd2; s_axi_arburst = 2'd1;
      s_axi_arvalid = 1'b1;
      n = 0;
      while (!s_axi_arready && n < 50) begin @(posedge aclk); #1; n++; end
      @(posedge aclk); #1;
      s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b1;
      chk("mid_b0_data", s_axi_rdata, 32'hA0);
      @(posedge aclk); #1;
      chk("mid_b1_data", s_axi_rdata, 32'hA1);
      areset = 1'b1;
      #1;
      chk("mid_rst_rvalid", s_axi_rvalid, 0);
      chk("mid_rst_arready", s_axi_arready, 0);
      chk("mid_rst_rdata", s_axi_rdata, 0);
      s_axi_rready = 1'b0;
      @(posedge aclk); #1;
      areset = 1'b0;
      @(posedge aclk); #1;
      chk("mid_rel_arready", s_axi_arready, 1);
      read_burst(32'h100, 8'd3, 2'd1, 1'b0);
      for (int i = 0; i < 4; i++) chk("mid_after_data", rb_dat[i], 32'hA0 + i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
